// File: rtl/mul8_seq_ctrl.sv
// ============================================================================
// Module   : mul8_seq_ctrl
// Brief    : 8x8 unsigned multiplier sequencing one 4x4 Dadda core over four
//            cycles, with valid/ready handshakes. Optional macro ZERO_SKIP_EN
//            short-cuts zero operands straight to DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul8_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      p,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_step;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [15:0]      r_acc;
  logic [15:0]      r_p;
  logic [CNT_W-1:0] r_op_count;

  logic             w_accept;
  logic             w_consume;
  logic             w_zero;
  logic [3:0]       w_an;
  logic [3:0]       w_bn;
  logic [15:0]      w_pb;
  logic [7:0]       w_pp;
  logic [15:0]      w_pp_sh;
  logic [15:0]      w_acc_sum;

`ifdef ZERO_SKIP_EN
  assign w_zero = (a == 8'd0) || (b == 8'd0);
`else
  assign w_zero = 1'b0;
`endif

  // Step bit 0 selects the high nibble of a, step bit 1 the high nibble of b.
  assign w_an = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_bn = r_step[1] ? r_b[7:4] : r_b[3:0];

  always_comb begin
    w_pb = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_pb[i*4+j] = w_an[j] & w_bn[i];
      end
    end
  end

  // Dadda reduction 4 -> 3 -> 2 rows, then one 8-bit carry-propagate add.
  logic w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;
  logic w_s4, w_c4, w_s5, w_c5, w_s6, w_c6;
  logic [6:0] w_row_x;
  logic [6:0] w_row_y;

  assign w_s1 = w_pb[3] ^ w_pb[6];
  assign w_c1 = w_pb[3] & w_pb[6];
  assign w_s2 = w_pb[7] ^ w_pb[10];
  assign w_c2 = w_pb[7] & w_pb[10];
  assign w_s3 = w_pb[2] ^ w_pb[5];
  assign w_c3 = w_pb[2] & w_pb[5];
  assign w_s4 = w_s1 ^ w_pb[9] ^ w_pb[12];
  assign w_c4 = (w_s1 & w_pb[9]) | (w_s1 & w_pb[12]) | (w_pb[9] & w_pb[12]);
  assign w_s5 = w_s2 ^ w_pb[13] ^ w_c1;
  assign w_c5 = (w_s2 & w_pb[13]) | (w_s2 & w_c1) | (w_pb[13] & w_c1);
  assign w_s6 = w_pb[11] ^ w_pb[14] ^ w_c2;
  assign w_c6 = (w_pb[11] & w_pb[14]) | (w_pb[11] & w_c2) | (w_pb[14] & w_c2);

  assign w_row_x = {w_pb[15], w_s6, w_s5, w_s4, w_s3, w_pb[1], w_pb[0]};
  assign w_row_y = {w_c6, w_c5, w_c4, w_c3, w_pb[8], w_pb[4], 1'b0};
  assign w_pp    = {1'b0, w_row_x} + {1'b0, w_row_y};

  always_comb begin
    w_pp_sh = 16'h0000;
    case (r_step)
      2'd0:    w_pp_sh = {8'h00, w_pp};
      2'd3:    w_pp_sh = {w_pp, 8'h00};
      default: w_pp_sh = {4'h0, w_pp, 4'h0};
    endcase
  end

  assign w_acc_sum = r_acc + w_pp_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_consume   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_step == 2'd3) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_consume   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        busy        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step     <= 2'd0;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_acc      <= 16'h0000;
      r_p        <= 16'h0000;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_acc  <= 16'h0000;
        r_step <= 2'd0;
        if (w_zero) begin
          r_p <= 16'h0000;
        end
      end else if (r_state == S_CALC) begin
        r_acc  <= w_acc_sum;
        r_step <= r_step + 2'd1;
        if (r_step == 2'd3) begin
          r_p <= w_acc_sum;
        end
      end
      if (w_consume) begin
        r_op_count <= r_op_count + c_cnt_one;
      end
    end
  end

  assign p        = r_p;
  assign op_count = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_mul8_seq_ctrl.sv
// ============================================================================
// Module   : tb_mul8_seq_ctrl
// Brief    : Directed and randomised-operand bench for mul8_seq_ctrl against a
//            latency/queue model of the handshake and product arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul8_seq_ctrl;

`ifdef ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] p;
  logic        busy;
  logic [7:0]  op_count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  mul8_seq_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: an accepted pair becomes a*b after a fixed latency, then waits
  // for out_ready; everything else is ignored while a product is in flight.
  bit          m_idle = 1'b1;
  bit          m_valid = 1'b0;
  logic [15:0] m_p = 16'h0000;
  logic [15:0] m_prod = 16'h0000;
  logic [7:0]  m_cnt = 8'h00;
  int          m_cd = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_valid = 1'b0; m_p = 16'h0000; m_cnt = 8'h00; m_cd = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle = 1'b0;
        m_prod = 16'(a) * 16'(b);
        if (ZS && (a == 8'h00 || b == 8'h00)) begin
          m_valid = 1'b1;
          m_p     = 16'h0000;
        end else begin
          m_cd = 4;
        end
      end
    end else if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        m_valid = 1'b1;
        m_p     = m_prod;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
      m_cnt   = m_cnt + 8'h01;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_ready",  32'(in_ready),  32'(m_idle));
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      chk("model_busy",      32'(busy),      32'(!m_idle));
      chk("model_p",         32'(p),         32'(m_p));
      chk("model_op_count",  32'(op_count),  32'(m_cnt));
    end
  end

  // One full transaction; lat is edges after the accept edge until out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] exp_p, input int lat, input int bp);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_v; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    a = 8'($urandom); b = 8'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("product", 32'(p), 32'(exp_p));
    in_valid = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_p_stable",  32'(p),         32'(exp_p));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_consume_valid", 32'(out_valid), 32'd0);
    chk("post_consume_ready", 32'(in_ready),  32'd1);
    chk("p_held_in_idle",     32'(p),         32'(exp_p));
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] rp;
    int          rl;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_p",         32'(p),         32'h0000);
    chk("rst_op_count",  32'(op_count),  32'd0);
    chk_en = 1'b1;

    // Reset lands on the edge that would perform step 2.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h55; b = 8'h66;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    chk("midrst_p",        32'(p),        32'h0000);
    chk("midrst_op_count", 32'(op_count), 32'd0);

    run_op(8'h12, 8'h34, 16'h03A8, 4, 0);
    chk("basic_op_count", 32'(op_count), 32'd1);
    run_op(8'hFF, 8'hFF, 16'hFE01, 4, 0);
    run_op(8'h0F, 8'hF0, 16'h0E10, 4, 0);
    run_op(8'h80, 8'h02, 16'h0100, 4, 10);
    run_op(8'h00, 8'hAB, 16'h0000, ZS ? 0 : 4, 2);
    run_op(8'h03, 8'h05, 16'h000F, 4, 1);
    chk("directed_op_count", 32'(op_count), 32'd6);

    for (int k = 0; k < 250; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (k == 10) ra = 8'h00;
      if (k == 20) rb = 8'h00;
      rp = 16'(ra) * 16'(rb);
      rl = (ZS && (ra == 8'h00 || rb == 8'h00)) ? 0 : 4;
      run_op(ra, rb, rp, rl, int'($urandom_range(0, 2)));
    end
    chk("wrap_op_count", 32'(op_count), 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
